// File: rtl/boardman_bridge_pkg.sv
// Shared constants for the board-manager bus bridge: FSM encoding, region
// select field position and the default read data for a timed-out read.
package boardman_bridge_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAITLOW = 2'd2;

  localparam int NUM_SLAVES = 4;
  localparam int SEL_HI     = 19;
  localparam int SEL_LO     = 18;

  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hBAADF00D;

endpackage

// File: rtl/boardman_bridge_timer.sv
// Access watchdog: 16-bit up-counter with clear and enable; o_expire flags the
// last allowed cycle of an un-acked access.
module boardman_bridge_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expire = i_en && (r_count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/boardman_bus_bridge.sv
// Address-decoding bridge: routes each single-master register access to one of
// four slave regions and force-completes accesses that a slave never acks.
module boardman_bus_bridge
  import boardman_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = DEFAULT_TIMEOUT_DATA
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [19:0]               s_adr_i,
  input  logic [31:0]               s_dat_i,
  output logic [31:0]               s_dat_o,
  input  logic                      s_en_i,
  input  logic                      s_wr_i,
  input  logic [3:0]                s_wstrb_i,
  output logic                      s_ack_o,
  output logic [17:0]               m_adr_o,
  output logic [31:0]               m_dat_o,
  output logic                      m_wr_o,
  output logic [3:0]                m_wstrb_o,
  output logic [NUM_SLAVES-1:0]     m_en_o,
  input  logic [32*NUM_SLAVES-1:0]  m_dat_i,
  input  logic [NUM_SLAVES-1:0]     m_ack_i,
  output logic                      timeout_o,
  output logic [15:0]               timeout_count_o,
  output logic [1:0]                state_o
);

  // Upstream: s_en_i is held high and stable until the single-cycle s_ack_o;
  // a new request is only taken once s_en_i has been seen low (WAITLOW->IDLE).
  // Downstream: m_en_o[n] stays high until m_ack_i[n] or the timeout fires.

  logic [1:0]            r_state;
  logic [1:0]            r_sel;
  logic [17:0]           r_m_adr;
  logic [31:0]           r_m_dat;
  logic                  r_m_wr;
  logic [3:0]            r_m_wstrb;
  logic [NUM_SLAVES-1:0] r_m_en;
  logic                  r_s_ack;
  logic [31:0]           r_s_dat;
  logic                  r_timeout;
  logic [15:0]           r_timeout_count;

  logic                  w_capture;
  logic                  w_issue;
  logic                  w_expire;
  logic                  w_sel_ack;
  logic [31:0]           w_sel_dat;

  assign w_capture = (r_state == ST_IDLE) && s_en_i;
  assign w_issue   = (r_state == ST_ISSUE);
  assign w_sel_ack = m_ack_i[r_sel];
  assign w_sel_dat = m_dat_i[{r_sel, 5'b00000} +: 32];

  boardman_bridge_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_capture),
    .i_en     (w_issue),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_WAITLOW;
      r_sel           <= '0;
      r_m_adr         <= '0;
      r_m_dat         <= '0;
      r_m_wr          <= 1'b0;
      r_m_wstrb       <= '0;
      r_m_en          <= '0;
      r_s_ack         <= 1'b0;
      r_s_dat         <= '0;
      r_timeout       <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      r_s_ack   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s_en_i) begin
            r_m_adr   <= s_adr_i[17:0];
            r_m_dat   <= s_dat_i;
            r_m_wr    <= s_wr_i;
            r_m_wstrb <= s_wstrb_i;
            r_sel     <= s_adr_i[SEL_HI:SEL_LO];
            r_m_en    <= NUM_SLAVES'(1) << s_adr_i[SEL_HI:SEL_LO];
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A genuine ack in the expiry cycle takes priority over the timeout.
          if (w_sel_ack) begin
            r_m_en  <= '0;
            r_s_ack <= 1'b1;
            if (!r_m_wr) r_s_dat <= w_sel_dat;
            r_state <= ST_WAITLOW;
          end else if (w_expire) begin
            r_m_en    <= '0;
            r_s_ack   <= 1'b1;
            r_timeout <= 1'b1;
            if (!r_m_wr) r_s_dat <= TIMEOUT_DATA;
            if (r_timeout_count != 16'hFFFF) r_timeout_count <= r_timeout_count + 16'd1;
            r_state   <= ST_WAITLOW;
          end
        end
        ST_WAITLOW: begin
          if (!s_en_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_WAITLOW;
      endcase
    end
  end

  assign s_dat_o         = r_s_dat;
  assign s_ack_o         = r_s_ack;
  assign m_adr_o         = r_m_adr;
  assign m_dat_o         = r_m_dat;
  assign m_wr_o          = r_m_wr;
  assign m_wstrb_o       = r_m_wstrb;
  assign m_en_o          = r_m_en;
  assign timeout_o       = r_timeout;
  assign timeout_count_o = r_timeout_count;
  assign state_o         = r_state;

endmodule

// File: tb/tb_boardman_bus_bridge.sv
// Directed bench for boardman_bus_bridge with TIMEOUT=16: routing, same-cycle
// ack, timeout, ack/expiry race, mid-access reset and counter saturation.
module tb_boardman_bus_bridge;

  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [19:0]  s_adr_i;
  logic [31:0]  s_dat_i;
  logic [31:0]  s_dat_o;
  logic         s_en_i;
  logic         s_wr_i;
  logic [3:0]   s_wstrb_i;
  logic         s_ack_o;
  logic [17:0]  m_adr_o;
  logic [31:0]  m_dat_o;
  logic         m_wr_o;
  logic [3:0]   m_wstrb_o;
  logic [3:0]   m_en_o;
  logic [127:0] m_dat_i;
  logic [3:0]   m_ack_i;
  logic         timeout_o;
  logic [15:0]  timeout_count_o;
  logic [1:0]   state_o;

  int n_cmp = 0;
  int n_err = 0;

  boardman_bus_bridge #(
    .TIMEOUT      (TO),
    .TIMEOUT_DATA (32'hBAADF00D)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_adr_i         (s_adr_i),
    .s_dat_i         (s_dat_i),
    .s_dat_o         (s_dat_o),
    .s_en_i          (s_en_i),
    .s_wr_i          (s_wr_i),
    .s_wstrb_i       (s_wstrb_i),
    .s_ack_o         (s_ack_o),
    .m_adr_o         (m_adr_o),
    .m_dat_o         (m_dat_o),
    .m_wr_o          (m_wr_o),
    .m_wstrb_o       (m_wstrb_o),
    .m_en_o          (m_en_o),
    .m_dat_i         (m_dat_i),
    .m_ack_i         (m_ack_i),
    .timeout_o       (timeout_o),
    .timeout_count_o (timeout_count_o),
    .state_o         (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks; sampling happens 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slaves(input logic [31:0] d3, input logic [31:0] d2,
                            input logic [31:0] d1, input logic [31:0] d0);
    m_dat_i = {d3, d2, d1, d0};
  endtask

  task automatic drive_req(input logic [19:0] adr, input logic [31:0] dat,
                           input logic wr, input logic [3:0] wstrb);
    s_adr_i   = adr;
    s_dat_i   = dat;
    s_wr_i    = wr;
    s_wstrb_i = wstrb;
    s_en_i    = 1'b1;
    tick();
  endtask

  task automatic end_req();
    s_en_i  = 1'b0;
    m_ack_i = 4'b0000;
    tick();
    check_val("ack_single_pulse", {31'b0, s_ack_o}, 32'd0);
  endtask

  task automatic run_timeout(input logic [19:0] adr, output int high_cycles);
    drive_req(adr, 32'h0, 1'b0, 4'hF);
    high_cycles = 0;
    while (m_en_o != 4'b0000 && high_cycles < 100) begin
      high_cycles++;
      tick();
    end
  endtask

  initial begin
    int hc;
    rst       = 1'b1;
    s_adr_i   = '0;
    s_dat_i   = '0;
    s_en_i    = 1'b0;
    s_wr_i    = 1'b0;
    s_wstrb_i = '0;
    m_ack_i   = '0;
    m_dat_i   = '0;
    repeat (3) tick();

    // reset state
    check_val("rst_state", {30'b0, state_o}, 32'd2);
    check_val("rst_m_en", {28'b0, m_en_o}, 32'd0);
    check_val("rst_s_ack", {31'b0, s_ack_o}, 32'd0);
    check_val("rst_s_dat", s_dat_o, 32'd0);
    check_val("rst_tcount", {16'b0, timeout_count_o}, 32'd0);
    check_val("rst_m_adr", {14'b0, m_adr_o}, 32'd0);
    rst = 1'b0;
    tick();

    // read region 2, ack three cycles after m_en rises
    set_slaves(32'h33333333, 32'h12345678, 32'h11111111, 32'h00000000);
    drive_req(20'h8_0004, 32'h0, 1'b0, 4'hF);
    check_val("rd_m_en", {28'b0, m_en_o}, 32'h4);
    check_val("rd_m_adr", {14'b0, m_adr_o}, 32'h0004);
    check_val("rd_m_wr", {31'b0, m_wr_o}, 32'd0);
    repeat (3) tick();
    check_val("rd_m_en_held", {28'b0, m_en_o}, 32'h4);
    check_val("rd_no_early_ack", {31'b0, s_ack_o}, 32'd0);
    m_ack_i = 4'b0100;
    tick();
    check_val("rd_s_ack", {31'b0, s_ack_o}, 32'd1);
    check_val("rd_s_dat", s_dat_o, 32'h12345678);
    check_val("rd_timeout", {31'b0, timeout_o}, 32'd0);
    check_val("rd_m_en_clr", {28'b0, m_en_o}, 32'd0);
    end_req();

    // write region 1, slave acks in the first enable cycle
    set_slaves(32'h0, 32'h0, 32'hDEADDEAD, 32'h0);
    drive_req(20'h4_0010, 32'hCAFEF00D, 1'b1, 4'b0011);
    check_val("wr_m_en", {28'b0, m_en_o}, 32'h2);
    check_val("wr_m_wr", {31'b0, m_wr_o}, 32'd1);
    check_val("wr_m_wstrb", {28'b0, m_wstrb_o}, 32'h3);
    check_val("wr_m_dat", m_dat_o, 32'hCAFEF00D);
    check_val("wr_m_adr", {14'b0, m_adr_o}, 32'h0010);
    m_ack_i = 4'b0010;
    tick();
    check_val("wr_s_ack", {31'b0, s_ack_o}, 32'd1);
    check_val("wr_s_dat_held", s_dat_o, 32'h12345678);
    end_req();

    // read region 3, never acked
    set_slaves(32'h77777777, 32'h0, 32'h0, 32'h0);
    run_timeout(20'hC_0123, hc);
    check_val("to_en_cycles", hc, TO);
    check_val("to_s_ack", {31'b0, s_ack_o}, 32'd1);
    check_val("to_pulse", {31'b0, timeout_o}, 32'd1);
    check_val("to_s_dat", s_dat_o, 32'hBAADF00D);
    check_val("to_count", {16'b0, timeout_count_o}, 32'd1);
    check_val("to_m_adr_held", {14'b0, m_adr_o}, 32'h0123);
    m_ack_i = 4'b1000;
    tick();
    check_val("late_ack_s_ack", {31'b0, s_ack_o}, 32'd0);
    check_val("late_ack_pulse", {31'b0, timeout_o}, 32'd0);
    check_val("late_ack_s_dat", s_dat_o, 32'hBAADF00D);
    end_req();

    // stray ack on slave 0, then slave 2 acks exactly at expiry
    set_slaves(32'h0, 32'h55AA33CC, 32'h0, 32'h99999999);
    drive_req(20'h8_0020, 32'h0, 1'b0, 4'hF);
    tick();
    m_ack_i = 4'b0001;
    repeat (3) tick();
    m_ack_i = 4'b0000;
    check_val("stray_s_ack", {31'b0, s_ack_o}, 32'd0);
    check_val("stray_m_en", {28'b0, m_en_o}, 32'h4);
    repeat (TO - 5) tick();
    check_val("race_m_en_last", {28'b0, m_en_o}, 32'h4);
    m_ack_i = 4'b0100;
    tick();
    check_val("race_s_ack", {31'b0, s_ack_o}, 32'd1);
    check_val("race_s_dat", s_dat_o, 32'h55AA33CC);
    check_val("race_no_pulse", {31'b0, timeout_o}, 32'd0);
    check_val("race_count", {16'b0, timeout_count_o}, 32'd1);
    end_req();

    // reset in the middle of an access with s_en held high
    set_slaves(32'h0, 32'h0, 32'h0, 32'hA5A50042);
    drive_req(20'h0_0042, 32'h0, 1'b0, 4'hF);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_m_en", {28'b0, m_en_o}, 32'd0);
    check_val("mid_rst_s_ack", {31'b0, s_ack_o}, 32'd0);
    check_val("mid_rst_s_dat", s_dat_o, 32'd0);
    check_val("mid_rst_count", {16'b0, timeout_count_o}, 32'd0);
    m_ack_i = 4'b0001;
    repeat (3) tick();
    check_val("held_en_m_en", {28'b0, m_en_o}, 32'd0);
    check_val("held_en_s_ack", {31'b0, s_ack_o}, 32'd0);
    end_req();
    drive_req(20'h0_0042, 32'h0, 1'b0, 4'hF);
    check_val("rerun_m_en", {28'b0, m_en_o}, 32'h1);
    m_ack_i = 4'b0001;
    tick();
    check_val("rerun_s_ack", {31'b0, s_ack_o}, 32'd1);
    check_val("rerun_s_dat", s_dat_o, 32'hA5A50042);
    end_req();

    // timeout counter saturation
    force dut.r_timeout_count = 16'hFFFE;
    #1;
    release dut.r_timeout_count;
    check_val("sat_preload", {16'b0, timeout_count_o}, 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      run_timeout(20'hC_0000, hc);
      check_val("sat_pulse", {31'b0, timeout_o}, 32'd1);
      check_val("sat_count", {16'b0, timeout_count_o}, 32'hFFFF);
      end_req();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
